// File: rtl/config_frame_writer_pkg.sv
// Shared types and elaboration helpers for the configuration frame writer.
// Encodings are fixed so readback logic and benches can decode the state directly.
package config_frame_writer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StPulse = 2'd2,
        StHold  = 2'd3
    } state_e;

    // Width of a frame index; a single-frame column still needs a 1-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the phase counter: wide enough for the largest phase length.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/config_frame_writer_if.sv
// Frame write request channel between the bitstream loader and the frame writer.
// The loader drives the request side; the writer returns ready.
interface config_frame_writer_if
    import config_frame_writer_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 32,
    parameter int unsigned MAX_FRAMES = 20
) ();

    localparam int unsigned IdxW = idx_width(MAX_FRAMES);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [IdxW-1:0]       wr_frame;
    logic [FRAME_BITS-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_frame,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_frame,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/config_frame_writer.sv
// Writer side of the fabric configuration-latch interface: one frame per request,
// driven through a fixed setup / pulse / hold sequence with fully registered outputs.
module config_frame_writer
    import config_frame_writer_pkg::*;
#(
    parameter int unsigned FRAME_BITS   = 32,
    parameter int unsigned MAX_FRAMES   = 20,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    config_frame_writer_if.slave    wr,
    output logic [FRAME_BITS-1:0]   FrameData,
    output logic [MAX_FRAMES-1:0]   FrameStrobe,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned IdxW = idx_width(MAX_FRAMES);
    localparam int unsigned CntW = cnt_width(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);

    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] PulseLoad  = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);
    localparam logic [IdxW:0]   FrameLimit = (IdxW + 1)'(MAX_FRAMES);

    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
        $error("config_frame_writer: SETUP/PULSE/HOLD_CYCLES must all be >= 1");
    end

    if (MAX_FRAMES < 1 || FRAME_BITS < 1) begin : g_bad_geometry
        $error("config_frame_writer: MAX_FRAMES and FRAME_BITS must be >= 1");
    end

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       frame_q, frame_d;
    logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
    logic [MAX_FRAMES-1:0] frame_strobe_q, frame_strobe_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic accept;
    logic in_range;

    assign accept   = wr.wr_valid & wr_ready_q;
    assign in_range = ({1'b0, wr.wr_frame} < FrameLimit);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        frame_data_d = frame_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_range) begin
                        frame_d      = wr.wr_frame;
                        frame_data_d = wr.wr_data;
                        cnt_d        = SetupLoad;
                        state_d      = StSetup;
                    end else begin
                        // Bad index is consumed so the loader never stalls on it.
                        err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = PulseLoad;
                    state_d = StPulse;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so every port comes from a flop.
        frame_strobe_d = (state_d == StPulse) ? (MAX_FRAMES'(1) << frame_d) : '0;
        wr_ready_d     = (state_d == StIdle);
        busy_d         = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            frame_q        <= '0;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            wr_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_q        <= frame_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            wr_ready_q     <= wr_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

    strobe_onehot0_a: assert property (@(posedge CLK) disable iff (RST)
        $onehot0(FrameStrobe));

    strobe_only_when_busy_a: assert property (@(posedge CLK) disable iff (RST)
        (|FrameStrobe) |-> busy);

    data_stable_while_busy_a: assert property (@(posedge CLK) disable iff (RST)
        busy |=> $stable(FrameData));

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: scoreboard of expected strobes,
// latch-row model, and directed reset / out-of-range / stall scenarios.
module tb_config_frame_writer;

    localparam int unsigned FrameBits = 32;
    localparam int unsigned MaxFrames = 20;
    localparam int unsigned SetupA    = 1;
    localparam int unsigned PulseA    = 1;
    localparam int unsigned HoldA     = 1;
    localparam int unsigned IdxW      = 5;
    localparam int unsigned MaxWait   = 64;

    typedef struct {
        int          frame;
        logic [31:0] data;
        time         acc_t;
    } sb_item_t;

    logic clk;
    logic rst_a, rst_b;

    logic [FrameBits-1:0] data_a, data_b;
    logic [MaxFrames-1:0] strobe_a, strobe_b;
    logic busy_a, done_a, err_a;
    logic busy_b, done_b, err_b;

    config_frame_writer_if #(.FRAME_BITS(FrameBits), .MAX_FRAMES(MaxFrames)) ifa ();
    config_frame_writer_if #(.FRAME_BITS(FrameBits), .MAX_FRAMES(MaxFrames)) ifb ();

    config_frame_writer #(
        .FRAME_BITS  (FrameBits),
        .MAX_FRAMES  (MaxFrames),
        .SETUP_CYCLES(SetupA),
        .PULSE_CYCLES(PulseA),
        .HOLD_CYCLES (HoldA)
    ) dut_a (
        .CLK        (clk),
        .RST        (rst_a),
        .wr         (ifa),
        .FrameData  (data_a),
        .FrameStrobe(strobe_a),
        .busy       (busy_a),
        .done       (done_a),
        .err        (err_a)
    );

    config_frame_writer #(
        .FRAME_BITS  (FrameBits),
        .MAX_FRAMES  (MaxFrames),
        .SETUP_CYCLES(3),
        .PULSE_CYCLES(3),
        .HOLD_CYCLES (3)
    ) dut_b (
        .CLK        (clk),
        .RST        (rst_b),
        .wr         (ifb),
        .FrameData  (data_b),
        .FrameStrobe(strobe_b),
        .busy       (busy_b),
        .done       (done_b),
        .err        (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and monitor state for DUT A.
    sb_item_t    sb_q[$];
    sb_item_t    cur;
    logic [19:0] prev_strobe = '0;
    logic [31:0] prev_data   = '0;
    int          width       = 0;
    int          done_cnt    = 0;
    int          err_cnt     = 0;
    int          exp_done    = 0;
    int          exp_err     = 0;
    bit          b2b_mode    = 1'b0;
    bit          have_rise   = 1'b0;
    time         last_rise_t = 0;
    logic [31:0] latch_q [MaxFrames];

    // Level-sensitive config latch row model.
    always @(strobe_a or data_a) begin
        for (int i = 0; i < MaxFrames; i++) begin
            if (strobe_a[i]) latch_q[i] = data_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_a) begin
            if (done_a) done_cnt++;
            if (err_a) err_cnt++;
            if (strobe_a != '0 && prev_strobe == '0) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_strobe", 64'(strobe_a), 64'd0);
                end else begin
                    cur = sb_q.pop_front();
                    check_eq("strobe_onehot", 64'(strobe_a), 64'(20'd1 << cur.frame));
                    check_eq("data_at_rise", 64'(data_a), 64'(cur.data));
                    check_eq("data_setup", 64'(prev_data), 64'(cur.data));
                    // Inclusive edge count: accept edge through the edge that raises the strobe.
                    check_eq("rise_latency", 64'(($time - 5 - cur.acc_t) / 10 + 1),
                             64'(SetupA + 1));
                    if (b2b_mode && have_rise)
                        check_eq("rise_spacing", 64'(($time - last_rise_t) / 10),
                                 64'(SetupA + PulseA + HoldA + 1));
                    have_rise   = 1'b1;
                    last_rise_t = $time;
                end
                width = 1;
            end else if (strobe_a != '0) begin
                width++;
            end else if (prev_strobe != '0) begin
                check_eq("pulse_width", 64'(width), 64'(PulseA));
                check_eq("data_hold", 64'(data_a), 64'(cur.data));
            end
        end
        prev_strobe = strobe_a;
        prev_data   = data_a;
    end

    // Present a request on A from a falling edge and return on the accepting rising edge.
    task automatic send_a(input int f, input logic [31:0] d);
        int n;
        @(negedge clk);
        ifa.wr_valid = 1'b1;
        ifa.wr_frame = IdxW'(f);
        ifa.wr_data  = d;
        for (n = 0; n < MaxWait; n++) begin
            if (ifa.wr_ready) break;
            @(negedge clk);
        end
        if (n == MaxWait) begin
            check_eq("ready_timeout", 64'(ifa.wr_ready), 64'd1);
            return;
        end
        @(posedge clk);
        if (f < MaxFrames) begin
            sb_q.push_back('{frame: f, data: d, acc_t: $time});
            exp_done++;
        end else begin
            exp_err++;
        end
    endtask

    logic [31:0] saved;
    logic [31:0] w_stall;
    logic [31:0] w_new;
    logic [19:0] exp_strobe;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.wr_valid = 1'b0;
        ifa.wr_frame = '0;
        ifa.wr_data  = '0;
        ifb.wr_valid = 1'b0;
        ifb.wr_frame = '0;
        ifb.wr_data  = '0;

        // 1. Reset held for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strobe", 64'(strobe_a), 64'd0);
        check_eq("rst_data", 64'(data_a), 64'd0);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_done", 64'(done_a), 64'd0);
        check_eq("rst_err", 64'(err_a), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 64'(ifa.wr_ready), 64'd1);

        // 2. Single write to frame 5.
        send_a(5, 32'hA5A5_0F0F);
        @(negedge clk);
        ifa.wr_valid = 1'b0;
        check_eq("single_busy", 64'(busy_a), 64'd1);
        check_eq("single_ready_low", 64'(ifa.wr_ready), 64'd0);
        check_eq("single_setup_strobe", 64'(strobe_a), 64'd0);
        @(negedge clk);
        check_eq("single_strobe", 64'(strobe_a), 64'h20);
        @(negedge clk);
        check_eq("single_hold_strobe", 64'(strobe_a), 64'd0);
        check_eq("single_hold_done", 64'(done_a), 64'd0);
        @(negedge clk);
        check_eq("single_done", 64'(done_a), 64'd1);
        check_eq("single_busy_end", 64'(busy_a), 64'd0);
        check_eq("single_ready_end", 64'(ifa.wr_ready), 64'd1);
        @(negedge clk);
        check_eq("single_done_once", 64'(done_a), 64'd0);
        check_eq("single_latch5", 64'(latch_q[5]), 64'hA5A5_0F0F);

        // 3. Back-to-back frames 0..19 with wr_valid held high.
        b2b_mode  = 1'b1;
        have_rise = 1'b0;
        for (int i = 0; i < MaxFrames; i++) begin
            send_a(i, 32'hC0DE_0000 + 32'(i) * 32'h0101);
        end
        @(negedge clk);
        ifa.wr_valid = 1'b0;
        repeat (6) @(negedge clk);
        b2b_mode = 1'b0;
        for (int i = 0; i < MaxFrames; i++) begin
            check_eq($sformatf("latch_row%0d", i), 64'(latch_q[i]),
                     64'(32'hC0DE_0000 + 32'(i) * 32'h0101));
        end

        // 4. Out-of-range frame index.
        saved = 32'hC0DE_0000 + 32'(MaxFrames - 1) * 32'h0101;
        send_a(20, 32'hDEAD_BEEF);
        @(negedge clk);
        ifa.wr_valid = 1'b0;
        check_eq("oor_err", 64'(err_a), 64'd1);
        check_eq("oor_strobe", 64'(strobe_a), 64'd0);
        check_eq("oor_data", 64'(data_a), 64'(saved));
        check_eq("oor_ready", 64'(ifa.wr_ready), 64'd1);
        check_eq("oor_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        check_eq("oor_err_once", 64'(err_a), 64'd0);
        check_eq("oor_strobe_later", 64'(strobe_a), 64'd0);

        // 6. Stall: junk requests while busy must be ignored.
        w_stall = 32'h1357_9BDF;
        send_a(7, w_stall);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ifa.wr_valid = k[0];
            ifa.wr_frame = IdxW'($urandom_range(0, MaxFrames - 1));
            ifa.wr_data  = $urandom;
            check_eq("stall_data", 64'(data_a), 64'(w_stall));
        end
        @(negedge clk);
        ifa.wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("stall_latch7", 64'(latch_q[7]), 64'(w_stall));
        check_eq("stall_idle", 64'(busy_a), 64'd0);

        // 5. Reset during the 2nd PULSE cycle of the slow instance.
        @(negedge clk);
        ifb.wr_valid = 1'b1;
        ifb.wr_frame = IdxW'(2);
        ifb.wr_data  = 32'h0BAD_F00D;
        check_eq("b_ready", 64'(ifb.wr_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ifb.wr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("b_pulse_before_rst", 64'(strobe_b), 64'h4);
        rst_b = 1'b1;
        @(negedge clk);
        check_eq("b_rst_strobe", 64'(strobe_b), 64'd0);
        check_eq("b_rst_data", 64'(data_b), 64'd0);
        check_eq("b_rst_busy", 64'(busy_b), 64'd0);
        rst_b = 1'b0;
        @(negedge clk);
        check_eq("b_ready_after_rst", 64'(ifb.wr_ready), 64'd1);
        w_new = 32'h600D_CAFE;
        ifb.wr_valid = 1'b1;
        ifb.wr_frame = IdxW'(1);
        ifb.wr_data  = w_new;
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            ifb.wr_valid = 1'b0;
            exp_strobe = (k >= 3 && k <= 5) ? 20'h2 : 20'h0;
            check_eq($sformatf("b_strobe_k%0d", k), 64'(strobe_b), 64'(exp_strobe));
            check_eq($sformatf("b_done_k%0d", k), 64'(done_b), 64'(k == 9));
            if (k < 9) check_eq($sformatf("b_data_k%0d", k), 64'(data_b), 64'(w_new));
        end
        check_eq("b_err_quiet", 64'(err_b), 64'd0);

        check_eq("done_count", 64'(done_cnt), 64'(exp_done));
        check_eq("err_count", 64'(err_cnt), 64'(exp_err));
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
